// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared state type, default sizes and one-hot helper for the demux scheduler
package demux_sched_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int N_OUT_DEF = 8;
  localparam int DW_DEF = 8;
  function automatic logic [31:0] onehot(input int unsigned s);
    return 32'd1 << s;
  endfunction
endpackage

// File: rtl/demux_rr_sched_rr_pick.sv
// rr_pick: first set bit of mask at or after ptr, searching circularly
module rr_pick #(
  parameter int N = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);
  localparam logic [SELW:0] NW = (SELW+1)'(N);
  logic [N-1:0] rot;
  logic [SELW:0] off, sum;
  always_comb begin
    rot = N'({mask, mask} >> ptr);
    off = '0;
    for (int i = N-1; i >= 0; i--) if (rot[i]) off = (SELW+1)'(i);
    sum = {1'b0, ptr} + off;
    idx = (sum >= NW) ? SELW'(sum - NW) : SELW'(sum);
    any = |mask;
  end
endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: registers input words and steers a one-hot valid to one consumer (round-robin or directed)
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int DW = DW_DEF,
  parameter int SELW = $clog2(N_OUT),
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N_OUT-1:0] chan_mask,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic [SELW-1:0]  in_dest,
  output logic             in_ready,
  output logic [N_OUT-1:0] out_valid,
  output logic [DW-1:0]    out_data,
  input  logic [N_OUT-1:0] out_ready,
  output logic [SELW-1:0]  sel,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic             stall_err,
  input  logic             clr_err
);
  localparam logic [15:0] TO = 16'(TIMEOUT);
  state_t state_q, state_d;
  logic [N_OUT-1:0] out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] sel_q, sel_d, rr_ptr_q, rr_ptr_d, rr_idx, tgt;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic stall_err_q, stall_err_d;
  logic rr_any, done, load_ok, dest_ok, tgt_ok, acc, load, drop, stalled;

  rr_pick #(.N(N_OUT), .SELW(SELW)) u_pick (
    .mask(chan_mask),
    .ptr (rr_ptr_q),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    busy = state_q == SEND;
    done = busy & out_ready[sel_q];
    load_ok = en & (!busy | done);
    dest_ok = ({1'b0, in_dest} < (SELW+1)'(N_OUT)) && chan_mask[in_dest];
    tgt = mode ? in_dest : rr_idx;
    tgt_ok = mode ? dest_ok : rr_any;
    // directed words with a bad destination are still accepted so they can be dropped
    in_ready = load_ok & (mode | rr_any) & !rst;
    acc = in_valid & in_ready;
    load = acc & tgt_ok;
    drop = acc & !tgt_ok;
    stalled = busy & !out_ready[sel_q];
    state_d = load ? SEND : done ? IDLE : state_q;
    out_valid_d = load ? N_OUT'(onehot(32'(tgt))) : done ? '0 : out_valid_q;
    out_data_d = load ? in_data : out_data_q;
    sel_d = load ? tgt : sel_q;
    rr_ptr_d = (load & !mode) ? ((tgt == SELW'(N_OUT-1)) ? '0 : tgt + 1'b1) : rr_ptr_q;
    stall_cnt_d = !stalled ? '0 : (stall_cnt_q == TO) ? stall_cnt_q : stall_cnt_q + 16'd1;
    stall_err_d = clr_err ? 1'b0 : (stalled && stall_cnt_d == TO) ? 1'b1 : stall_err_q;
    drop_cnt_d = clr_err ? {7'd0, drop} : (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_valid_q <= '0;
      out_data_q <= '0;
      sel_q <= '0;
      rr_ptr_q <= '0;
      drop_cnt_q <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      sel_q <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign sel = sel_q;
  assign drop_cnt = drop_cnt_q;
  assign stall_err = stall_err_q;
endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: scoreboard bench for the demux scheduler with a small reference model
module tb_demux_rr_sched;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0, in_valid = 1'b0, clr_err = 1'b0;
  logic [7:0] chan_mask = 8'hFF, in_data = '0, out_ready = 8'hFF;
  logic [2:0] in_dest = '0;
  logic in_ready, busy, stall_err;
  logic [7:0] out_valid, out_data, drop_cnt;
  logic [2:0] sel;
  int n_chk = 0, n_pass = 0;

  typedef struct {int ch; logic [7:0] d;} item_t;
  item_t q[$];
  int m_ptr = 0, m_drop = 0, m_cnt = 0;
  logic m_err = 1'b0;

  demux_rr_sched #(.N_OUT(8), .DW(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .chan_mask(chan_mask),
    .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .sel(sel),
    .busy(busy), .drop_cnt(drop_cnt), .stall_err(stall_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  task automatic step();
    int t;
    logic done, exp_rdy, ok, dropped;
    @(negedge clk);
    t = 0;
    ok = 1'b0;
    dropped = 1'b0;
    done = q.size() > 0 && out_ready[q[0].ch];
    exp_rdy = en && (q.size() == 0 || done) && (mode || |chan_mask);
    chk("in_ready", in_ready, exp_rdy);
    chk("busy", busy, q.size() > 0);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("stall_err", stall_err, m_err);
    if (q.size() > 0) begin
      chk("out_valid", out_valid, 32'd1 << q[0].ch);
      chk("out_data", out_data, q[0].d);
      chk("sel", sel, q[0].ch);
    end else chk("out_valid_idle", out_valid, 0);
    if (q.size() > 0 && !out_ready[q[0].ch]) begin
      m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      if (m_cnt == 4) m_err = 1'b1;
    end else m_cnt = 0;
    if (clr_err) m_err = 1'b0;
    if (done) void'(q.pop_front());
    if (in_valid && exp_rdy) begin
      if (mode) begin
        t = in_dest;
        ok = chan_mask[in_dest];
      end else begin
        for (int i = 7; i >= 0; i--) if (chan_mask[(m_ptr + i) % 8]) t = (m_ptr + i) % 8;
        ok = 1'b1;
        m_ptr = (t + 1) % 8;
      end
      if (ok) q.push_back('{t, in_data});
      else begin
        dropped = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end
    if (clr_err) m_drop = dropped ? 1 : 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b1;
    in_valid = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_stall_err", stall_err, 0);
    in_valid = 1'b0;
    #9 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data = 8'hD0 + 8'(k);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chan_mask = 8'b1010_0100;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = 8'h20 + 8'(k);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    mode = 1'b1;
    chan_mask = 8'hFF;
    in_dest = 3'd3;
    in_data = 8'h33;
    out_ready = 8'b0000_0010;
    in_valid = 1'b1;
    step();
    in_data = 8'h44;
    repeat (5) step();
    out_ready = 8'hFF;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chan_mask = 8'b1011_1111;
    in_dest = 3'd6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    repeat (300) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    in_valid = 1'b0;
    repeat (2) step();
    mode = 1'b0;
    chan_mask = 8'hFF;
    out_ready = 8'h00;
    in_data = 8'h5A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    step();
    out_ready = 8'hFF;
    repeat (2) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    out_ready = 8'h00;
    in_data = 8'h77;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sel", sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 0);
    q.delete();
    m_ptr = 0;
    m_cnt = 0;
    m_err = 1'b0;
    m_drop = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 8'hFF;
    in_data = 8'hC0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
